// File: rtl/wb_arbiter2.sv
// Two-master, one-slave Wishbone arbiter: round-robin ownership held per cyc window,
// with a watchdog that error-terminates strobes the slave never acknowledges.
module wb_arbiter2 #(
   parameter int unsigned TIMEOUT  = 16,
   parameter logic [31:0] ERR_DATA = 32'hdeadbeef
) (
   input  logic        wb_clk_i,
   input  logic        reset,
   input  logic        m0_cyc_i,
   input  logic        m0_stb_i,
   input  logic        m0_we_i,
   input  logic [3:0]  m0_sel_i,
   input  logic [31:0] m0_adr_i,
   input  logic [31:0] m0_dat_i,
   output logic        m0_ack_o,
   output logic        m0_err_o,
   output logic [31:0] m0_dat_o,
   input  logic        m1_cyc_i,
   input  logic        m1_stb_i,
   input  logic        m1_we_i,
   input  logic [3:0]  m1_sel_i,
   input  logic [31:0] m1_adr_i,
   input  logic [31:0] m1_dat_i,
   output logic        m1_ack_o,
   output logic        m1_err_o,
   output logic [31:0] m1_dat_o,
   output logic        s_cyc_o,
   output logic        s_stb_o,
   output logic        s_we_o,
   output logic [3:0]  s_sel_o,
   output logic [31:0] s_adr_o,
   output logic [31:0] s_dat_o,
   input  logic        s_ack_i,
   input  logic [31:0] s_dat_i,
   output logic [1:0]  grant_o,
   output logic [7:0]  timeout_cnt_o
);

   // Handshake: a strobe completes in the cycle the granted master sees ack or err;
   // both are combinational from the slave/watchdog and never high together.
   typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

   localparam logic [7:0] WDOG_LIMIT = 8'(TIMEOUT - 1);

   state_t     state, state_nxt;
   logic       last, last_nxt;
   logic [7:0] wdog, wdog_nxt;
   logic       err_pend, err_pend_nxt;
   logic [7:0] tcnt, tcnt_nxt;

   always_ff @(posedge wb_clk_i) begin
      if (reset) begin
         state    <= IDLE;
         last     <= 1'b1;
         wdog     <= 8'd0;
         err_pend <= 1'b0;
         tcnt     <= 8'd0;
      end else begin
         state    <= state_nxt;
         last     <= last_nxt;
         wdog     <= wdog_nxt;
         err_pend <= err_pend_nxt;
         tcnt     <= tcnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      last_nxt     = last;
      wdog_nxt     = wdog;
      err_pend_nxt = 1'b0;
      tcnt_nxt     = tcnt;
      s_cyc_o      = 1'b0;
      s_stb_o      = 1'b0;
      s_we_o       = 1'b0;
      s_sel_o      = 4'd0;
      s_adr_o      = 32'd0;
      s_dat_o      = 32'd0;
      m0_ack_o     = 1'b0;
      m0_err_o     = 1'b0;
      m0_dat_o     = 32'd0;
      m1_ack_o     = 1'b0;
      m1_err_o     = 1'b0;
      m1_dat_o     = 32'd0;
      case (state)
         IDLE: begin
            if (m0_cyc_i && m1_cyc_i) state_nxt = last ? GNT0 : GNT1;
            else if (m0_cyc_i)        state_nxt = GNT0;
            else if (m1_cyc_i)        state_nxt = GNT1;
         end
         GNT0: begin
            s_cyc_o  = m0_cyc_i;
            s_stb_o  = m0_stb_i & ~err_pend;
            s_we_o   = m0_we_i;
            s_sel_o  = m0_sel_i;
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            m0_ack_o = s_ack_i & ~err_pend;
            m0_err_o = err_pend;
            m0_dat_o = err_pend ? ERR_DATA : s_dat_i;
            if (!m0_cyc_i) begin
               state_nxt = IDLE;
               last_nxt  = 1'b0;
            end
         end
         GNT1: begin
            s_cyc_o  = m1_cyc_i;
            s_stb_o  = m1_stb_i & ~err_pend;
            s_we_o   = m1_we_i;
            s_sel_o  = m1_sel_i;
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            m1_ack_o = s_ack_i & ~err_pend;
            m1_err_o = err_pend;
            m1_dat_o = err_pend ? ERR_DATA : s_dat_i;
            if (!m1_cyc_i) begin
               state_nxt = IDLE;
               last_nxt  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase

      // An ack in the limit cycle clears the counter before the limit test is reached.
      if (state == IDLE || state_nxt == IDLE || !s_stb_o || s_ack_i) begin
         wdog_nxt = 8'd0;
      end else if (wdog == WDOG_LIMIT) begin
         wdog_nxt     = 8'd0;
         err_pend_nxt = 1'b1;
         tcnt_nxt     = (tcnt == 8'hff) ? tcnt : tcnt + 8'd1;
      end else begin
         wdog_nxt = wdog + 8'd1;
      end
   end

   assign grant_o       = {state == GNT1, state == GNT0};
   assign timeout_cnt_o = tcnt;

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2: reset, single read, contention, locked sequence,
// watchdog timeout, ack at the watchdog limit and reset mid-strobe.
module tb_wb_arbiter2;

   logic        wb_clk_i;
   logic        reset;
   logic        m0_cyc_i, m0_stb_i, m0_we_i;
   logic [3:0]  m0_sel_i;
   logic [31:0] m0_adr_i, m0_dat_i;
   logic        m0_ack_o, m0_err_o;
   logic [31:0] m0_dat_o;
   logic        m1_cyc_i, m1_stb_i, m1_we_i;
   logic [3:0]  m1_sel_i;
   logic [31:0] m1_adr_i, m1_dat_i;
   logic        m1_ack_o, m1_err_o;
   logic [31:0] m1_dat_o;
   logic        s_cyc_o, s_stb_o, s_we_o;
   logic [3:0]  s_sel_o;
   logic [31:0] s_adr_o, s_dat_o;
   logic        s_ack_i;
   logic [31:0] s_dat_i;
   logic [1:0]  grant_o;
   logic [7:0]  timeout_cnt_o;

   int checks = 0;
   int errors = 0;

   wb_arbiter2 #(.TIMEOUT(16), .ERR_DATA(32'hdeadbeef)) dut (
      .wb_clk_i(wb_clk_i), .reset(reset),
      .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
      .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
      .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_dat_o(m0_dat_o),
      .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
      .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
      .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_dat_o(m1_dat_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
      .s_ack_i(s_ack_i), .s_dat_i(s_dat_i),
      .grant_o(grant_o), .timeout_cnt_o(timeout_cnt_o)
   );

   initial wb_clk_i = 1'b0;
   always #5 wb_clk_i = ~wb_clk_i;

   task automatic next_cycle;
      @(posedge wb_clk_i);
      #1;
   endtask

   task automatic settle;
      @(negedge wb_clk_i);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      s_dat_i = 32'h12345678;
      repeat (3) next_cycle();
      settle();
      checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL rst_grant got %b exp 00", grant_o); end
      checks++; if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b000 || s_sel_o !== 4'd0 || s_adr_o !== 32'd0 || s_dat_o !== 32'd0) begin
         errors++; $display("FAIL rst_slave cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h exp all 0", s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o); end
      checks++; if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== 4'b0000 || m0_dat_o !== 32'd0 || m1_dat_o !== 32'd0) begin
         errors++; $display("FAIL rst_masters ack/err=%b%b%b%b d0=%h d1=%h exp 0", m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, m0_dat_o, m1_dat_o); end
      checks++; if (timeout_cnt_o !== 8'd0) begin errors++; $display("FAIL rst_tcnt got %0d exp 0", timeout_cnt_o); end
      next_cycle();
      reset = 1'b0;
   endtask

   task automatic test_contention;
      logic [1:0] exp_g;
      for (int r = 0; r < 4; r++) begin
         exp_g = r[0] ? 2'b10 : 2'b01;
         next_cycle();
         m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h30000000;
         m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'h30000008;
         settle();
         checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL cont_idle r=%0d got %b exp 00", r, grant_o); end
         next_cycle();
         s_ack_i = 1'b1; s_dat_i = 32'h1000 + 32'(r);
         settle();
         checks++; if (grant_o !== exp_g) begin errors++; $display("FAIL cont_grant r=%0d got %b exp %b", r, grant_o, exp_g); end
         checks++; if ({m1_ack_o, m0_ack_o} !== exp_g) begin errors++; $display("FAIL cont_ack r=%0d got %b%b exp %b", r, m1_ack_o, m0_ack_o, exp_g); end
         checks++; if ((exp_g[0] ? m1_dat_o : m0_dat_o) !== 32'd0 || (exp_g[0] ? m0_dat_o : m1_dat_o) !== 32'h1000 + 32'(r)) begin
            errors++; $display("FAIL cont_dat r=%0d d0=%h d1=%h", r, m0_dat_o, m1_dat_o); end
         next_cycle();
         s_ack_i = 1'b0;
         m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
         settle();
         checks++; if (s_cyc_o !== 1'b0 || grant_o !== exp_g) begin errors++; $display("FAIL cont_drop r=%0d s_cyc=%b grant=%b exp 0/%b", r, s_cyc_o, grant_o, exp_g); end
      end
      next_cycle();
   endtask

   task automatic test_single_read;
      next_cycle();
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b0; m0_sel_i = 4'hf; m0_adr_i = 32'h30000004;
      settle();
      checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL read_pre_grant got %b exp 00", grant_o); end
      next_cycle();
      settle();
      checks++; if (grant_o !== 2'b01) begin errors++; $display("FAIL read_grant got %b exp 01", grant_o); end
      checks++; if (s_cyc_o !== 1'b1 || s_stb_o !== 1'b1 || s_adr_o !== 32'h30000004 || s_sel_o !== 4'hf || m0_ack_o !== 1'b0) begin
         errors++; $display("FAIL read_route cyc=%b stb=%b adr=%h sel=%h ack=%b", s_cyc_o, s_stb_o, s_adr_o, s_sel_o, m0_ack_o); end
      next_cycle();
      s_ack_i = 1'b1; s_dat_i = 32'h4669626f;
      settle();
      checks++; if (m0_ack_o !== 1'b1 || m0_dat_o !== 32'h4669626f) begin errors++; $display("FAIL read_data ack=%b dat=%h exp 1/4669626f", m0_ack_o, m0_dat_o); end
      checks++; if (m1_ack_o !== 1'b0 || m1_err_o !== 1'b0 || m1_dat_o !== 32'd0 || m0_err_o !== 1'b0) begin
         errors++; $display("FAIL read_other m1 ack=%b err=%b dat=%h m0_err=%b exp 0", m1_ack_o, m1_err_o, m1_dat_o, m0_err_o); end
      next_cycle();
      s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
      next_cycle();
      settle();
      checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL read_release got %b exp 00", grant_o); end
   endtask

   task automatic test_locked;
      next_cycle();
      m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1; m1_sel_i = 4'h3;
      m1_adr_i = 32'h30000010; m1_dat_i = 32'h0000aaaa;
      next_cycle();
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h30000020;
      s_ack_i = 1'b1;
      settle();
      checks++; if (grant_o !== 2'b10 || m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0) begin
         errors++; $display("FAIL lock_s1 grant=%b ack1=%b ack0=%b exp 10/1/0", grant_o, m1_ack_o, m0_ack_o); end
      checks++; if (s_adr_o !== 32'h30000010 || s_we_o !== 1'b1 || s_sel_o !== 4'h3 || s_dat_o !== 32'h0000aaaa) begin
         errors++; $display("FAIL lock_route adr=%h we=%b sel=%h dat=%h", s_adr_o, s_we_o, s_sel_o, s_dat_o); end
      next_cycle();
      s_ack_i = 1'b0; m1_stb_i = 1'b0;
      settle();
      checks++; if (grant_o !== 2'b10 || s_stb_o !== 1'b0) begin errors++; $display("FAIL lock_gap grant=%b stb=%b exp 10/0", grant_o, s_stb_o); end
      for (int s = 0; s < 2; s++) begin
         next_cycle();
         m1_stb_i = 1'b1; m1_adr_i = 32'h30000014 + 32'(4 * s); s_ack_i = 1'b1;
         settle();
         checks++; if (grant_o !== 2'b10 || m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0) begin
            errors++; $display("FAIL lock_s%0d grant=%b ack1=%b ack0=%b", s + 2, grant_o, m1_ack_o, m0_ack_o); end
      end
      next_cycle();
      s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0;
      settle();
      checks++; if (grant_o !== 2'b10) begin errors++; $display("FAIL lock_drop got %b exp 10", grant_o); end
      next_cycle();
      settle();
      checks++; if (grant_o !== 2'b00) begin errors++; $display("FAIL lock_idle got %b exp 00", grant_o); end
      next_cycle();
      s_ack_i = 1'b1; s_dat_i = 32'h00c0ffee;
      settle();
      checks++; if (grant_o !== 2'b01 || m0_ack_o !== 1'b1 || m0_dat_o !== 32'h00c0ffee) begin
         errors++; $display("FAIL lock_m0 grant=%b ack=%b dat=%h exp 01/1/00c0ffee", grant_o, m0_ack_o, m0_dat_o); end
      next_cycle();
      s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
      next_cycle();
   endtask

   task automatic test_timeout;
      next_cycle();
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h30000030;
      s_ack_i = 1'b0; s_dat_i = 32'h5a5a5a5a;
      for (int k = 0; k < 18; k++) begin
         next_cycle();
         settle();
         checks++; if (m0_err_o !== (k == 16) || m0_ack_o !== 1'b0) begin
            errors++; $display("FAIL tmo_k%0d err=%b ack=%b exp %b/0", k, m0_err_o, m0_ack_o, k == 16); end
         if (k == 16) begin
            checks++; if (m0_dat_o !== 32'hdeadbeef || s_stb_o !== 1'b0 || timeout_cnt_o !== 8'd1) begin
               errors++; $display("FAIL tmo_term dat=%h stb=%b tcnt=%0d exp deadbeef/0/1", m0_dat_o, s_stb_o, timeout_cnt_o); end
         end
      end
      next_cycle();
      m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
      next_cycle();
   endtask

   task automatic test_ack_at_limit;
      next_cycle();
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
      for (int k = 0; k < 18; k++) begin
         next_cycle();
         s_ack_i = (k == 15); s_dat_i = 32'h0000_0100 + 32'(k);
         settle();
         checks++; if (m0_err_o !== 1'b0 || m0_ack_o !== (k == 15)) begin
            errors++; $display("FAIL lim_k%0d err=%b ack=%b exp 0/%b", k, m0_err_o, m0_ack_o, k == 15); end
      end
      checks++; if (timeout_cnt_o !== 8'd1) begin errors++; $display("FAIL lim_tcnt got %0d exp 1", timeout_cnt_o); end
      next_cycle();
      s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
      next_cycle();
   endtask

   task automatic test_reset_mid;
      next_cycle();
      m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'h30000040;
      next_cycle();
      settle();
      checks++; if (grant_o !== 2'b10 || s_stb_o !== 1'b1) begin errors++; $display("FAIL rmid_pre grant=%b stb=%b exp 10/1", grant_o, s_stb_o); end
      next_cycle();
      reset = 1'b1;
      settle();
      checks++; if (m1_ack_o !== 1'b0 || m1_err_o !== 1'b0) begin errors++; $display("FAIL rmid_hold ack=%b err=%b exp 0/0", m1_ack_o, m1_err_o); end
      for (int k = 0; k < 2; k++) begin
         next_cycle();
         settle();
         checks++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || grant_o !== 2'b00 || m1_ack_o !== 1'b0 || m1_err_o !== 1'b0) begin
            errors++; $display("FAIL rmid_post%0d cyc=%b stb=%b grant=%b ack=%b err=%b exp 0/0/00/0/0", k, s_cyc_o, s_stb_o, grant_o, m1_ack_o, m1_err_o); end
      end
      checks++; if (timeout_cnt_o !== 8'd0) begin errors++; $display("FAIL rmid_tcnt got %0d exp 0", timeout_cnt_o); end
      next_cycle();
      reset = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
      next_cycle();
   endtask

   initial begin
      reset = 1'b1;
      m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0; m0_sel_i = 4'd0; m0_adr_i = 32'd0; m0_dat_i = 32'd0;
      m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0; m1_sel_i = 4'd0; m1_adr_i = 32'd0; m1_dat_i = 32'd0;
      s_ack_i = 1'b0; s_dat_i = 32'd0;
      test_reset();
      test_contention();
      test_single_read();
      test_locked();
      test_timeout();
      test_ack_at_limit();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
